eth_out_port_sched: RTL

// - Per-output-port packet scheduler for the ethernet switch; one instance per egress port.
// - Shares the egress port between N_REQ ingress queues (34-bit FWFT FIFO heads: [33]=eop, [32]=sop, [31:0]=data).
// - Arbitrates round-robin at packet granularity: grant held SOP..EOP, pops the winning queue, drives registered egress.
// - Enforces a max-packet-length watchdog and flushes runaway packets.

---
 rtl/eth_sw_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/eth_out_port_sched.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/eth_sw_pkg.sv
// Shared types and field positions for the ethernet switch datapath.
package eth_sw_pkg;

  // Queue head word: [33]=eop, [32]=sop, [31:0]=data.
  typedef logic [33:0] eth_word_t;

  localparam int unsigned WORD_W  = 34;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SOP_BIT = 32;
  localparam int unsigned EOP_BIT = 33;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr (mod N) wins.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan N positions starting one past the last winner; keep the first hit.
  always_comb begin
    int unsigned k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      k = (32'(ptr) + off) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/eth_out_port_sched.sv
// Egress port scheduler: packet-granular round-robin between ingress queue heads,
// registered egress, and a max-length watchdog that truncates and flushes runaway packets.
module eth_out_port_sched
  import eth_sw_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned MAX_PKT_WORDS = 64
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [N_REQ-1:0]        head_vld,
  input  logic [N_REQ-1:0]        head_dst_me,
  input  logic [N_REQ*WORD_W-1:0] head_data,
  output logic [N_REQ-1:0]        rd_en,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       outData,
  output logic                    outSop,
  output logic                    outEop,
  output logic                    outErr,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  sched_state_t      state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  gidx_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sop_q;
  logic              out_eop_q;
  logic              out_err_q;

  eth_word_t         heads [N_REQ];
  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  eth_word_t         g_word;
  logic              g_vld;
  logic              xfer_go;
  logic              flush_go;
  logic [CNT_W-1:0]  cnt_inc;
  logic              at_max;

  // Unpack queue heads; only a head that starts a packet for this port may compete.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      heads[i] = head_data[i*WORD_W +: WORD_W];
      cand[i]  = head_vld[i] & heads[i][SOP_BIT] & head_dst_me[i];
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req (cand),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Owner's head word and the two pop conditions.
  always_comb begin
    g_word   = heads[gidx_q];
    g_vld    = head_vld[gidx_q];
    xfer_go  = (state_q == XFER) && g_vld && out_ready;
    flush_go = (state_q == FLUSH) && g_vld;
    cnt_inc  = word_cnt_q + CNT_W'(1);
    at_max   = (cnt_inc == CNT_W'(MAX_PKT_WORDS));
  end

  // Pop decode; held off during reset so queue contents are left untouched.
  always_comb begin
    rd_en = '0;
    if (resetN && (xfer_go || flush_go)) begin
      rd_en[gidx_q] = 1'b1;
    end
  end

  // Scheduler FSM with registered egress, word counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
      word_cnt_q <= '0;
      out_data_q <= '0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      // Framing outputs are single-cycle pulses; data holds between transfers.
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q  <= arb_gnt;
            gidx_q   <= arb_idx;
            rr_ptr_q <= arb_idx;
            state_q  <= XFER;
          end
        end
        XFER: begin
          if (xfer_go) begin
            out_data_q <= g_word[DATA_W-1:0];
            out_sop_q  <= g_word[SOP_BIT];
            out_eop_q  <= g_word[EOP_BIT];
            word_cnt_q <= cnt_inc;
            if (g_word[EOP_BIT]) begin
              state_q    <= IDLE;
              grant_q    <= '0;
              word_cnt_q <= '0;
            end else if (at_max) begin
              // Truncate: close the packet on the egress with an error marker.
              out_eop_q <= 1'b1;
              out_err_q <= 1'b1;
              state_q   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_go && g_word[EOP_BIT]) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            word_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outData = out_data_q;
  assign outSop  = out_sop_q;
  assign outEop  = out_eop_q;
  assign outErr  = out_err_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule
